// File: rtl/mat_mult_ctrl.sv
// Sequencer for one 6x6 mat_mult datapath: loads A/B operand words, clears and runs the
// datapath for one full pass, then streams the 36 result elements out row-major.
module mat_mult_ctrl #(
  parameter int unsigned N          = 6,
  parameter int unsigned W          = 27,
  parameter int unsigned RUN_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_last,
  output logic             mm_rst,
  output logic             mm_en,
  output logic [N*N*W-1:0] mm_dataa,
  output logic [N*N*W-1:0] mm_datab,
  input  logic [N*N*W-1:0] mm_result
);

  localparam int unsigned NumElem  = N * N;
  localparam int unsigned NumWords = 2 * NumElem;

  typedef enum logic [2:0] {StIdle, StLoad, StClear, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [6:0]       k_q, k_d;
  logic [3:0]       run_q, run_d;
  logic [5:0]       j_q, j_d;
  logic             done_q, done_d;
  logic [N*N*W-1:0] dataa_q, datab_q;

  logic             in_hs;
  logic             a_sel;
  logic [6:0]       elem_w;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    run_d   = run_q;
    j_d     = j_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          k_d     = '0;
        end
      end
      StLoad: begin
        if (in_valid) begin
          if (k_q == 7'(NumWords - 1)) begin
            state_d = StClear;
            k_d     = '0;
          end else begin
            k_d = k_q + 7'd1;
          end
        end
      end
      StClear: begin
        state_d = StRun;
        run_d   = '0;
      end
      StRun: begin
        if (run_q == 4'(RUN_CYCLES - 1)) begin
          state_d = StDrain;
          run_d   = '0;
          j_d     = '0;
        end else begin
          run_d = run_q + 4'd1;
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (j_q == 6'(NumElem - 1)) begin
            state_d = StIdle;
            j_d     = '0;
            done_d  = 1'b1;
          end else begin
            j_d = j_q + 6'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      run_q   <= '0;
      j_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      run_q   <= run_d;
      j_q     <= j_d;
      done_q  <= done_d;
    end
  end

  // Word k lands in element 35-k of A, then element 35-(k-36) of B.
  always_comb begin
    in_hs  = (state_q == StLoad) && in_valid;
    a_sel  = k_q < 7'(NumElem);
    elem_w = a_sel ? (7'(NumElem - 1) - k_q) : (7'(NumWords - 1) - k_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dataa_q <= '0;
      datab_q <= '0;
    end else if (in_hs) begin
      for (int unsigned e = 0; e < NumElem; e++) begin
        if (elem_w == 7'(e)) begin
          if (a_sel) dataa_q[e*W +: W] <= in_data;
          else       datab_q[e*W +: W] <= in_data;
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    if (state_q == StDrain) begin
      for (int unsigned e = 0; e < NumElem; e++) begin
        if (j_q == 6'(NumElem - 1 - e)) out_data = mm_result[e*W +: W];
      end
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign in_ready  = (state_q == StLoad);
  assign out_valid = (state_q == StDrain);
  assign out_last  = (state_q == StDrain) && (j_q == 6'(NumElem - 1));
  assign mm_rst    = rst || (state_q == StClear);
  assign mm_en     = (state_q == StRun);
  assign mm_dataa  = dataa_q;
  assign mm_datab  = datab_q;

endmodule
